// File: rtl/debounce_filter_pkg.sv
// Shared types and constants for the debounce filter: FSM state encoding and default qualify length.
package debounce_filter_pkg;

    // 10 ms at 50 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous bit; two-cycle latency, reset value parameterised.
// No backpressure: samples every clock.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/debounce_filter.sv
// Debounces a raw mechanical input: accepts a new level after DEBOUNCE_CYCLES consecutive synced samples.
// Latency DEBOUNCE_CYCLES+2 clocks from a stable input change; no backpressure.
module debounce_filter
    import debounce_filter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sigIn,
    output logic sigOut,
    output logic busy
);

    localparam int               CNT_W       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam state_e           RESET_STATE = RESET_LEVEL ? IDLE_HIGH : IDLE_LOW;

    logic             s2;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sig_out_q, sig_out_d;

    sync_2ff #(
        .RESET_VAL(RESET_LEVEL)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (sigIn),
        .q_o  (s2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            cnt_q     <= '0;
            sig_out_q <= RESET_LEVEL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sig_out_q <= sig_out_d;
        end
    end

    // Any sample disagreeing with the candidate level drops back to idle with no partial credit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sig_out_d = sig_out_q;
        case (state_q)
            IDLE_LOW: begin
                if (s2) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s2) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_HIGH;
                    sig_out_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s2) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE_LOW;
                    sig_out_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RESET_STATE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
    end

    assign sigOut = sig_out_q;

endmodule
